io_output_bank: RTL and testbench
=================================

# io_output_bank

Memory-mapped bank of NUM_PORTS parametrised output registers on the pipeline computer's I/O bus, driven by CPU store cycles through write_io_enable. Each port supports plain write, bit set/clear/toggle and a self-clearing timed pulse, with byte enables and a registered readback path so software can read port state back. It replaces single-port, always-written output registers for LED/segment/GPIO outputs.

## Interface
Parameters:
- NUM_PORTS, 4, number of output ports (1..16)
- DATA_W, 32, port width in bits (8, 16, 24 or 32)
- BASE_ADDR, 8'h80, byte address of port 0; word aligned; BASE_ADDR[7:2]+NUM_PORTS <= 64
- PULSE_LEN, 1000, pulse duration in io_clk cycles (1..65535)

Ports:
- io_clk  in  1  bus/I/O clock; all state changes on rising edge
- clr  in  1  asynchronous, active-high reset
- addr  in  32  byte address; [7:2] port word index, [10:8] operation; [31:11], [1:0] ignored
- datain  in  32  write data; bits [DATA_W-1:0] used
- write_io_enable  in  1  store strobe; no state change when 0
- byte_en  in  DATA_W/8  per-byte write mask for all operations
- out_ports  out  NUM_PORTS*DATA_W  port k at [k*DATA_W +: DATA_W]
- pulse_active  out  NUM_PORTS  bit k = 1 while port k pulse counter nonzero
- rd_data  out  DATA_W  registered readback of addressed port

## Operation
- Decode: port k hit when addr[7:2] == BASE_ADDR[7:2]+k, k < NUM_PORTS; else access ignored, rd_data loads 0.
- Effective data d = datain[DATA_W-1:0] with bytes whose byte_en bit is 0 forced to 0.
- Ops on hit with write_io_enable=1 (addr[10:8]):
  - 000 WRITE: out_k <= (out_k & ~M) | d, where M is byte_en expanded to bits.
  - 001 SET: out_k <= out_k | d.
  - 010 CLR: out_k <= out_k & ~d.
  - 011 TOGGLE: out_k <= out_k ^ d.
  - 100 PULSE: out_k <= out_k | d; pmask_k <= pmask_k | d; cnt_k <= PULSE_LEN (restart if already active).
  - 101-111: no effect.
- Pulse counter per port, 16 bits: if cnt_k != 0 decrement each cycle; in the cycle cnt_k == 1, out_k <= out_k & ~pmask_k, pmask_k <= 0.
- Simultaneous expiry and CPU op on the same port: expiry clear applied first, CPU op applied to that result (CPU wins on overlapping bits); PULSE op on expiry cycle restarts cnt_k = PULSE_LEN and pmask_k = d only.
- WRITE/SET/CLR/TOGGLE do not touch cnt_k or pmask_k; bits cleared or rewritten by software during a pulse are still cleared at expiry if in pmask_k.
- pulse_active[k] = (cnt_k != 0), from register.
- Readback: every cycle, independent of write_io_enable, rd_data <= out_k of decoded port (pre-update value), 0 on miss.

## Timing
- Reset (clr=1, async): out_ports, pmask, cnt, pulse_active, rd_data all 0 immediately; held while clr=1. Reset mid-pulse aborts pulse.
- Write latency: out_ports reflect op on the io_clk edge sampling write_io_enable=1; visible next cycle.
- Pulse: PULSE op at edge T raises bits at T; pulse_active high from T; bits and pulse_active fall at edge T+PULSE_LEN (exactly PULSE_LEN cycles high).
- rd_data: 1-cycle latency from addr; a read of port k in the same cycle as a write returns the old value.
- No back-pressure; one op per cycle accepted.

## Test plan
- Reset: drive clr=1 mid-operation -> out_ports=0, pulse_active=0, rd_data=0 asynchronously; after release a read of 0x80 returns 0.
- WRITE/byte_en: write 0x12345678 to 0x80 byte_en=4'b1111, then 0xAABBCCDD byte_en=4'b0101 -> port0 = 0x12BB56DD; write to 0x98 (NUM_PORTS=4) -> no port changes, rd_data=0.
- SET/CLR/TOGGLE on 0x184/0x284/0x384 (port1), d=0xF0 from 0x0F -> 0xFF, then CLR 0x0F -> 0xF0, then TOGGLE 0xFF -> 0x0F.
- PULSE with PULSE_LEN=5: PULSE 0x480 d=0x1 from 0 -> bit0 and pulse_active[0] high exactly 5 cycles, then 0; retrigger at cycle 3 -> high 3+5 cycles total.
- Expiry collision: SET 0x1 on port0 in the expiry cycle of pulse mask 0x1 -> bit0 stays 1, pulse_active[0]=0.
- Readback: alternate reads of ports 0..3 loaded with distinct values -> rd_data matches previous-cycle address each cycle.

Source files
------------

// File: rtl/io_output_bank.sv
// -----------------------------------------------------------------------------
// io_output_bank
// Memory-mapped bank of NUM_PORTS output registers on the I/O bus. CPU store
// cycles (write_io_enable) can plain-write, set, clear or toggle bits of a
// port, or start a self-clearing timed pulse on selected bits. The addressed
// port is also loaded into rd_data every cycle as a registered readback.
//
// Ports:
//   io_clk          bus/I/O clock, all state changes on the rising edge
//   clr             asynchronous active-high reset
//   addr            byte address: [7:2] port word index, [10:8] operation
//   datain          write data, bits [DATA_W-1:0] used
//   write_io_enable store strobe
//   byte_en         per-byte write mask, applies to every operation
//   out_ports       port k at [k*DATA_W +: DATA_W]
//   pulse_active    bit k high while port k pulse counter is nonzero
//   rd_data         registered readback of the addressed port (0 on miss)
// -----------------------------------------------------------------------------
module io_output_bank #(
   parameter int         NUM_PORTS = 4,
   parameter int         DATA_W    = 32,
   parameter logic [7:0] BASE_ADDR = 8'h80,
   parameter int         PULSE_LEN = 1000
) (
   input  logic                          io_clk,
   input  logic                          clr,
   input  logic [31:0]                   addr,
   input  logic [31:0]                   datain,
   input  logic                          write_io_enable,
   input  logic [DATA_W/8-1:0]           byte_en,
   output logic [NUM_PORTS*DATA_W-1:0]   out_ports,
   output logic [NUM_PORTS-1:0]          pulse_active,
   output logic [DATA_W-1:0]             rd_data
);

   localparam int         NB       = DATA_W / 8;
   localparam logic [5:0] BASE_IDX = BASE_ADDR[7:2];
   localparam logic [15:0] PULSE_CNT = 16'(PULSE_LEN);

   localparam logic [2:0] OP_WRITE  = 3'b000;
   localparam logic [2:0] OP_SET    = 3'b001;
   localparam logic [2:0] OP_CLR    = 3'b010;
   localparam logic [2:0] OP_TOGGLE = 3'b011;
   localparam logic [2:0] OP_PULSE  = 3'b100;

   logic [DATA_W-1:0] out_q   [NUM_PORTS];
   logic [DATA_W-1:0] out_d   [NUM_PORTS];
   logic [DATA_W-1:0] pmask_q [NUM_PORTS];
   logic [DATA_W-1:0] pmask_d [NUM_PORTS];
   logic [15:0]       cnt_q   [NUM_PORTS];
   logic [15:0]       cnt_d   [NUM_PORTS];
   logic [NUM_PORTS-1:0] pulse_active_q;
   logic [NUM_PORTS-1:0] pulse_active_d;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   logic [5:0]        word_idx_s;
   logic [5:0]        port_idx_s;
   logic              hit_s;
   logic [2:0]        op_s;
   logic [DATA_W-1:0] bmask_s;
   logic [DATA_W-1:0] d_s;

   // Address bits outside the decode and data bits beyond DATA_W carry no meaning.
   logic unused_s;
   assign unused_s = ^{addr[31:11], addr[1:0], datain};

   // Address decode, byte-mask expansion and effective write data.
   always_comb begin
      word_idx_s = addr[7:2];
      op_s       = addr[10:8];
      port_idx_s = word_idx_s - BASE_IDX;
      // Wrap-around of the subtraction is excluded by the >= test.
      hit_s      = (word_idx_s >= BASE_IDX) && ({1'b0, port_idx_s} < 7'(NUM_PORTS));
      bmask_s    = '0;
      for (int i = 0; i < NB; i++) begin
         bmask_s[i*8 +: 8] = {8{byte_en[i]}};
      end
      d_s = datain[DATA_W-1:0] & bmask_s;
   end

   // Per-port next state: pulse expiry first, then the CPU operation on top.
   always_comb begin
      rd_data_d = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         out_d[k]   = out_q[k];
         pmask_d[k] = pmask_q[k];
         cnt_d[k]   = cnt_q[k];

         if (cnt_q[k] != 16'd0) begin
            cnt_d[k] = cnt_q[k] - 16'd1;
            if (cnt_q[k] == 16'd1) begin
               out_d[k]   = out_q[k] & ~pmask_q[k];
               pmask_d[k] = '0;
            end else begin
               pmask_d[k] = pmask_q[k];
            end
         end else begin
            cnt_d[k] = cnt_q[k];
         end

         if (hit_s && (port_idx_s == 6'(k))) begin
            // Readback sees the value before this cycle's update.
            rd_data_d = out_q[k];
            if (write_io_enable) begin
               case (op_s)
                  OP_WRITE:  out_d[k] = (out_d[k] & ~bmask_s) | d_s;
                  OP_SET:    out_d[k] = out_d[k] | d_s;
                  OP_CLR:    out_d[k] = out_d[k] & ~d_s;
                  OP_TOGGLE: out_d[k] = out_d[k] ^ d_s;
                  OP_PULSE: begin
                     // pmask_d is already zero if this is the expiry cycle.
                     out_d[k]   = out_d[k] | d_s;
                     pmask_d[k] = pmask_d[k] | d_s;
                     cnt_d[k]   = PULSE_CNT;
                  end
                  default: out_d[k] = out_d[k];
               endcase
            end else begin
               out_d[k] = out_d[k];
            end
         end else begin
            out_d[k] = out_d[k];
         end

         pulse_active_d[k] = (cnt_d[k] != 16'd0);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge io_clk or posedge clr) begin
      if (clr) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            out_q[k]   <= '0;
            pmask_q[k] <= '0;
            cnt_q[k]   <= 16'd0;
         end
         pulse_active_q <= '0;
         rd_data_q      <= '0;
      end else begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            out_q[k]   <= out_d[k];
            pmask_q[k] <= pmask_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
         pulse_active_q <= pulse_active_d;
         rd_data_q      <= rd_data_d;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_PORTS; g++) begin : g_pack
         assign out_ports[g*DATA_W +: DATA_W] = out_q[g];
      end
   endgenerate

   assign pulse_active = pulse_active_q;
   assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_io_output_bank.sv
// -----------------------------------------------------------------------------
// tb_io_output_bank
// Directed bench for io_output_bank with NUM_PORTS=4, DATA_W=32,
// BASE_ADDR=8'h80, PULSE_LEN=5. Inputs change 1 ns after the rising edge and
// outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_io_output_bank;

   logic          io_clk;
   logic          clr;
   logic [31:0]   addr;
   logic [31:0]   datain;
   logic          write_io_enable;
   logic [3:0]    byte_en;
   logic [127:0]  out_ports;
   logic [3:0]    pulse_active;
   logic [31:0]   rd_data;

   int checks;
   int failures;

   io_output_bank #(
      .NUM_PORTS (4),
      .DATA_W    (32),
      .BASE_ADDR (8'h80),
      .PULSE_LEN (5)
   ) dut (
      .io_clk          (io_clk),
      .clr             (clr),
      .addr            (addr),
      .datain          (datain),
      .write_io_enable (write_io_enable),
      .byte_en         (byte_en),
      .out_ports       (out_ports),
      .pulse_active    (pulse_active),
      .rd_data         (rd_data)
   );

   initial io_clk = 1'b0;
   always #5 io_clk = ~io_clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge io_clk);
      #1;
   endtask

   // One store cycle, then the strobe drops again.
   task automatic op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      addr            = a;
      datain          = d;
      byte_en         = be;
      write_io_enable = 1'b1;
      step();
      write_io_enable = 1'b0;
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      clr             = 1'b1;
      addr            = 32'h0;
      datain          = 32'h0;
      write_io_enable = 1'b0;
      byte_en         = 4'h0;
      step();
      step();
      check("reset_out",   out_ports,    128'h0);
      check("reset_pa",    pulse_active, 128'h0);
      check("reset_rd",    rd_data,      128'h0);
      clr = 1'b0;
      step();

      // WRITE with byte enables
      op(32'h080, 32'h12345678, 4'b1111);
      check("write_full", out_ports[31:0], 128'h12345678);
      op(32'h080, 32'hAABBCCDD, 4'b0101);
      check("write_be", out_ports[31:0], 128'h12BB56DD);
      addr = 32'h080;
      step();
      check("read_p0", rd_data, 128'h12BB56DD);

      // Out-of-range port: nothing changes, readback 0
      op(32'h098, 32'hFFFFFFFF, 4'b1111);
      check("miss_out", out_ports, {96'h0, 32'h12BB56DD});
      check("miss_rd",  rd_data,   128'h0);

      // SET / CLR / TOGGLE on port 1
      op(32'h084, 32'h0000000F, 4'b1111);
      op(32'h184, 32'h000000F0, 4'b1111);
      check("set", out_ports[63:32], 128'hFF);
      op(32'h284, 32'h0000000F, 4'b1111);
      check("clr", out_ports[63:32], 128'hF0);
      op(32'h384, 32'h000000FF, 4'b1111);
      check("toggle", out_ports[63:32], 128'h0F);
      check("rd_old_on_write", rd_data, 128'hF0);
      op(32'h584, 32'h000000FF, 4'b1111);
      check("reserved_op", out_ports[63:32], 128'h0F);

      // Pulse of exactly 5 cycles on port 0 bit 0
      op(32'h080, 32'h0, 4'b1111);
      op(32'h480, 32'h1, 4'b1111);
      check("pulse_t0_bit", out_ports[31:0], 128'h1);
      check("pulse_t0_pa",  pulse_active,   128'h1);
      for (int i = 1; i < 5; i++) begin
         step();
         check("pulse_hold", {pulse_active, out_ports[31:0]}, {4'h1, 32'h1});
      end
      step();
      check("pulse_end", {pulse_active, out_ports[31:0]}, {4'h0, 32'h0});

      // Retrigger at cycle 3: high 8 cycles in total
      op(32'h480, 32'h1, 4'b1111);
      step();
      step();
      op(32'h480, 32'h1, 4'b1111);
      for (int i = 1; i < 5; i++) begin
         step();
         check("retrig_hold", {pulse_active, out_ports[31:0]}, {4'h1, 32'h1});
      end
      step();
      check("retrig_end", {pulse_active, out_ports[31:0]}, {4'h0, 32'h0});

      // SET in the expiry cycle wins over the clear
      op(32'h480, 32'h1, 4'b1111);
      for (int i = 1; i < 5; i++) step();
      op(32'h180, 32'h1, 4'b1111);
      check("expiry_set", {pulse_active, out_ports[31:0]}, {4'h0, 32'h1});
      step();
      check("expiry_set_hold", {pulse_active, out_ports[31:0]}, {4'h0, 32'h1});

      // PULSE in the expiry cycle: old mask clears, new mask only
      op(32'h480, 32'h3, 4'b1111);
      check("p2_start", out_ports[31:0], 128'h3);
      for (int i = 1; i < 5; i++) step();
      op(32'h480, 32'h4, 4'b1111);
      check("p2_restart", {pulse_active, out_ports[31:0]}, {4'h1, 32'h4});
      for (int i = 1; i < 5; i++) step();
      check("p2_before_end", out_ports[31:0], 128'h4);
      step();
      check("p2_end", {pulse_active, out_ports[31:0]}, {4'h0, 32'h0});

      // Readback follows the previous cycle's address
      op(32'h080, 32'hA0A0A0A0, 4'b1111);
      op(32'h084, 32'hB1B1B1B1, 4'b1111);
      op(32'h088, 32'hC2C2C2C2, 4'b1111);
      op(32'h08C, 32'hD3D3D3D3, 4'b1111);
      addr = 32'h080; step(); check("rb0", rd_data, 128'hA0A0A0A0);
      addr = 32'h088; step(); check("rb2", rd_data, 128'hC2C2C2C2);
      addr = 32'h084; step(); check("rb1", rd_data, 128'hB1B1B1B1);
      addr = 32'h08C; step(); check("rb3", rd_data, 128'hD3D3D3D3);
      addr = 32'h07C; step(); check("rb_below", rd_data, 128'h0);

      // Asynchronous reset in the middle of a pulse
      op(32'h480, 32'hFF, 4'b1111);
      addr = 32'h080;
      #1;
      clr = 1'b1;
      #1;
      check("async_out", out_ports,    128'h0);
      check("async_pa",  pulse_active, 128'h0);
      check("async_rd",  rd_data,      128'h0);
      step();
      check("reset_hold", out_ports, 128'h0);
      clr = 1'b0;
      step();
      check("post_reset_rd", rd_data, 128'h0);
      check("post_reset_pa", pulse_active, 128'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
